// File: rtl/prog_clock_div.sv
// prog_clock_div: multi-channel run-time programmable clock divider with period-aligned config apply
// Ports:
//   clk_in    - single clock, all logic on posedge
//   rst       - synchronous active-low reset
//   en        - per-channel run enable
//   sync      - one-cycle pulse restarting all enabled channels phase-aligned
//   cfg_valid - config write request; accepted when cfg_ready is high
//   cfg_ready - combinational: config slot for cfg_ch is free
//   cfg_ch    - target channel for the config write
//   cfg_div   - new divide factor (0 behaves as 1)
//   cfg_hi    - new high time in clk_in cycles (clamped to 1..div-1)
//   clk_out   - registered divided waveform per channel
//   tick      - registered one-cycle pulse at the start of each period
module prog_clock_div #(
  parameter int NCH = 4,
  parameter int CW = 11,
  parameter int DEF_DIV = 2,
  parameter int DEF_HI = 1,
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk_in,
  input  logic           rst,
  input  logic [NCH-1:0] en,
  input  logic           sync,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_div,
  input  logic [CW-1:0]  cfg_hi,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] tick
);
  logic [CW-1:0] cnt [NCH];
  logic [CW-1:0] div [NCH];
  logic [CW-1:0] hi [NCH];
  logic [CW-1:0] sdiv [NCH];
  logic [CW-1:0] shi [NCH];
  logic [CW-1:0] de [NCH];
  logic [CW-1:0] he [NCH];
  logic [CW-1:0] nc [NCH];
  logic [NCH-1:0] wrap;
  logic [NCH-1:0] active;
  logic [NCH-1:0] pending;
  // Out-of-range channels always look ready so a stray write is silently dropped.
  assign cfg_ready = (int'(cfg_ch) >= NCH) || !pending[cfg_ch];
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      de[i] = (div[i] == '0) ? CW'(1) : div[i];
      he[i] = (hi[i] == '0) ? CW'(1) : (hi[i] >= de[i] && de[i] >= CW'(2)) ? de[i] - CW'(1) : hi[i];
      wrap[i] = cnt[i] == de[i] - CW'(1);
      nc[i] = wrap[i] ? '0 : cnt[i] + CW'(1);
    end
  end
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      active <= '0;
      pending <= '0;
      clk_out <= '0;
      tick <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
        div[i] <= CW'(DEF_DIV);
        hi[i] <= CW'(DEF_HI);
        sdiv[i] <= CW'(DEF_DIV);
        shi[i] <= CW'(DEF_HI);
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        // Idle, start, stop, sync and wrap all begin a fresh period, so shadow values may land.
        if (pending[i] && (!active[i] || !en[i] || sync || wrap[i])) begin
          div[i] <= sdiv[i];
          hi[i] <= shi[i];
          pending[i] <= 1'b0;
        end
        // Accept needs pending==0, so it can never collide with the apply above.
        if (cfg_valid && cfg_ready && int'(cfg_ch) == i) begin
          sdiv[i] <= cfg_div;
          shi[i] <= cfg_hi;
          pending[i] <= 1'b1;
        end
        if (!en[i]) begin
          active[i] <= 1'b0;
          cnt[i] <= '0;
          clk_out[i] <= 1'b0;
          tick[i] <= 1'b0;
        end else if (!active[i] || sync) begin
          active[i] <= 1'b1;
          cnt[i] <= '0;
          clk_out[i] <= 1'b1;
          tick[i] <= 1'b1;
        end else begin
          cnt[i] <= nc[i];
          clk_out[i] <= nc[i] < he[i];
          tick[i] <= nc[i] == '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_prog_clock_div.sv
// tb_prog_clock_div: directed table-driven check of prog_clock_div
module tb_prog_clock_div;
  logic clk_in = 1'b0;
  logic rst = 1'b0;
  logic [3:0] en = '0;
  logic sync = 1'b0;
  logic cfg_valid = 1'b0;
  logic cfg_ready;
  logic [1:0] cfg_ch = '0;
  logic [10:0] cfg_div = '0;
  logic [10:0] cfg_hi = '0;
  logic [3:0] clk_out;
  logic [3:0] tick;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [3:0] en;
    logic sy;
    logic cv;
    logic [1:0] ch;
    logic [10:0] dv;
    logic [10:0] hv;
    logic [3:0] ec;
    logic [3:0] et;
    logic er;
  } vec_t;
  vec_t tv[$];
  prog_clock_div dut (
    .clk_in(clk_in), .rst(rst), .en(en), .sync(sync),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_hi(cfg_hi), .clk_out(clk_out), .tick(tick)
  );
  always #5 clk_in = ~clk_in;
  task automatic add(input logic [3:0] e, input logic sy, input logic cv, input logic [1:0] c,
                     input int d, input int h, input logic [3:0] ec, input logic [3:0] et, input logic er);
    tv.push_back('{e, sy, cv, c, 11'(d), 11'(h), ec, et, er});
  endtask
  task automatic chk(input string nm, input int k, input logic [3:0] a, input logic [3:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s step %0d got %b want %b", nm, k, a, e);
    end
  endtask
  task automatic step(input logic [3:0] e, input logic sy, input logic cv, input logic [1:0] c,
                      input logic [10:0] d, input logic [10:0] h);
    en = e;
    sync = sy;
    cfg_valid = cv;
    cfg_ch = c;
    cfg_div = d;
    cfg_hi = h;
    @(posedge clk_in);
    #1;
  endtask
  task automatic chk_all(input string nm, input int k, input logic [3:0] ec, input logic [3:0] et, input logic er);
    chk({nm, "_clk"}, k, clk_out, ec);
    chk({nm, "_tick"}, k, tick, et);
    chk({nm, "_rdy"}, k, {3'b0, cfg_ready}, {3'b0, er});
  endtask
  initial begin
    // default div 2 hi 1 on ch0
    add(4'b0001, 0, 0, 0, 0, 0, 4'b0001, 4'b0001, 1);
    add(4'b0001, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 1);
    add(4'b0001, 0, 0, 0, 0, 0, 4'b0001, 4'b0001, 1);
    add(4'b0001, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 1);
    // ch1 div 5 hi 2 programmed while idle
    add(4'b0001, 0, 1, 1, 5, 2, 4'b0001, 4'b0001, 0);
    add(4'b0001, 0, 0, 1, 0, 0, 4'b0000, 4'b0000, 1);
    add(4'b0011, 0, 0, 1, 0, 0, 4'b0011, 4'b0011, 1);
    add(4'b0011, 0, 0, 1, 0, 0, 4'b0010, 4'b0000, 1);
    add(4'b0011, 0, 0, 1, 0, 0, 4'b0001, 4'b0001, 1);
    add(4'b0011, 0, 0, 1, 0, 0, 4'b0000, 4'b0000, 1);
    add(4'b0011, 0, 0, 1, 0, 0, 4'b0001, 4'b0001, 1);
    add(4'b0011, 0, 0, 1, 0, 0, 4'b0010, 4'b0010, 1);
    add(4'b0011, 0, 0, 1, 0, 0, 4'b0011, 4'b0001, 1);
    add(4'b0001, 0, 0, 1, 0, 0, 4'b0000, 4'b0000, 1);
    // ch0 to div 5 hi 1 while running, then div 3 at cnt 1 plus a stalled div 4 hi 2
    add(4'b0001, 0, 1, 0, 5, 1, 4'b0001, 4'b0001, 0);
    add(4'b0001, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);
    add(4'b0001, 0, 0, 0, 0, 0, 4'b0001, 4'b0001, 1);
    add(4'b0001, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 1);
    add(4'b0001, 0, 1, 0, 3, 1, 4'b0000, 4'b0000, 0);
    add(4'b0001, 0, 1, 0, 4, 2, 4'b0000, 4'b0000, 0);
    add(4'b0001, 0, 1, 0, 4, 2, 4'b0000, 4'b0000, 0);
    add(4'b0001, 0, 1, 0, 4, 2, 4'b0001, 4'b0001, 1);
    add(4'b0001, 0, 1, 0, 4, 2, 4'b0000, 4'b0000, 0);
    add(4'b0001, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);
    add(4'b0001, 0, 0, 0, 0, 0, 4'b0001, 4'b0001, 1);
    add(4'b0001, 0, 0, 0, 0, 0, 4'b0001, 4'b0000, 1);
    add(4'b0001, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 1);
    // ch2 div 6 hi 3, out of phase with ch0, then sync
    add(4'b0001, 0, 1, 2, 6, 3, 4'b0000, 4'b0000, 0);
    add(4'b0001, 0, 0, 2, 0, 0, 4'b0001, 4'b0001, 1);
    add(4'b0101, 0, 0, 2, 0, 0, 4'b0101, 4'b0100, 1);
    add(4'b0101, 0, 0, 2, 0, 0, 4'b0100, 4'b0000, 1);
    add(4'b0101, 1, 0, 2, 0, 0, 4'b0101, 4'b0101, 1);
    add(4'b0101, 0, 0, 2, 0, 0, 4'b0101, 4'b0000, 1);
    add(4'b0101, 0, 0, 2, 0, 0, 4'b0100, 4'b0000, 1);
    add(4'b0001, 1, 0, 2, 0, 0, 4'b0001, 4'b0001, 1);
    // clamp: ch1 div 0
    add(4'b0001, 0, 1, 1, 0, 0, 4'b0001, 4'b0000, 0);
    add(4'b0001, 0, 0, 1, 0, 0, 4'b0000, 4'b0000, 1);
    add(4'b0011, 0, 0, 1, 0, 0, 4'b0010, 4'b0010, 1);
    add(4'b0011, 0, 0, 1, 0, 0, 4'b0011, 4'b0011, 1);
    add(4'b0011, 0, 0, 1, 0, 0, 4'b0011, 4'b0010, 1);
    // clamp: ch1 div 4 hi 9 -> hi 3
    add(4'b0011, 0, 1, 1, 4, 9, 4'b0010, 4'b0010, 0);
    add(4'b0011, 0, 0, 1, 0, 0, 4'b0010, 4'b0010, 1);
    add(4'b0011, 0, 0, 1, 0, 0, 4'b0011, 4'b0001, 1);
    add(4'b0011, 0, 0, 1, 0, 0, 4'b0011, 4'b0000, 1);
    add(4'b0011, 0, 0, 1, 0, 0, 4'b0000, 4'b0000, 1);
    add(4'b0011, 0, 0, 1, 0, 0, 4'b0010, 4'b0010, 1);
    // clamp: ch1 hi 0 -> hi 1
    add(4'b0011, 0, 1, 1, 4, 0, 4'b0011, 4'b0001, 0);
    add(4'b0011, 0, 0, 1, 0, 0, 4'b0011, 4'b0000, 0);
    add(4'b0011, 0, 0, 1, 0, 0, 4'b0000, 4'b0000, 0);
    add(4'b0011, 0, 0, 1, 0, 0, 4'b0010, 4'b0010, 1);
    add(4'b0011, 0, 0, 1, 0, 0, 4'b0001, 4'b0001, 1);
    add(4'b0011, 0, 0, 1, 0, 0, 4'b0001, 4'b0000, 1);
    step(4'b0000, 0, 0, 0, 0, 0);
    step(4'b0000, 0, 0, 0, 0, 0);
    chk_all("reset", 0, 4'b0000, 4'b0000, 1);
    rst = 1'b1;
    foreach (tv[k]) begin
      step(tv[k].en, tv[k].sy, tv[k].cv, tv[k].ch, tv[k].dv, tv[k].hv);
      chk_all("vec", k, tv[k].ec, tv[k].et, tv[k].er);
    end
    step(4'b0011, 0, 1, 0, 7, 3);
    chk({"pend", "_rdy"}, 0, {3'b0, cfg_ready}, 4'b0000);
    rst = 1'b0;
    step(4'b0011, 0, 0, 0, 0, 0);
    chk_all("midrst", 0, 4'b0000, 4'b0000, 1);
    rst = 1'b1;
    step(4'b0001, 0, 0, 0, 0, 0);
    chk_all("post", 0, 4'b0001, 4'b0001, 1);
    step(4'b0001, 0, 0, 0, 0, 0);
    chk_all("post", 1, 4'b0000, 4'b0000, 1);
    step(4'b0001, 0, 0, 0, 0, 0);
    chk_all("post", 2, 4'b0001, 4'b0001, 1);
    step(4'b0001, 0, 0, 0, 0, 0);
    chk_all("post", 3, 4'b0000, 4'b0000, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/prog_clock_div.md
Name: prog_clock_div

Overview:
- Multi-channel, run-time programmable clock divider. Generalises the fixed single-factor divider.
- Each of NCH channels produces a divided clock-enable waveform and a period-start tick from one clk_in.
- Divide factor and high time are set per channel at run time. New settings take effect only at a period boundary, so there are no runt pulses.
- Used by benches and by the sort datapath to derive slow strobes.

Parameters:
- NCH, 4, number of output channels (1..16).
- CW, 11, counter/config width; maximum divide factor 2^CW-1.
- DEF_DIV, 2, divide factor loaded into every channel at reset.
- DEF_HI, 1, high-time (cycles) loaded into every channel at reset.

Ports:
- clk_in, input, 1: single clock; all logic on posedge.
- rst, input, 1: synchronous, active-low reset.
- en, input, NCH: per-channel run enable.
- sync, input, 1: one-cycle pulse; restarts all enabled channels phase-aligned.
- cfg_valid, input, 1: config write request.
- cfg_ready, output, 1: config slot free for channel cfg_ch.
- cfg_ch, input, max(1,$clog2(NCH)): target channel.
- cfg_div, input, CW: new divide factor.
- cfg_hi, input, CW: new high time in clk_in cycles.
- clk_out, output, NCH: registered divided waveform per channel.
- tick, output, NCH: registered one-cycle pulse at start of each period.

Behaviour:
- Reset (rst==0 at posedge): all cnt=0, clk_out=0, tick=0, active=0, div=DEF_DIV, hi=DEF_HI, pending=0.
  - cfg_ready is combinational: cfg_ready = !pending[cfg_ch]. It is therefore 1 while in reset.
  - Reset mid-operation discards pending configs and drops outputs at the next edge.
- Per-channel state: cnt[CW], active, div, hi, shadow div/hi, pending.
- Effective values:
  - div_e = (div==0) ? 1 : div.
  - hi_e = (hi==0) ? 1 : (hi>=div_e && div_e>=2) ? div_e-1 : hi.
  - For div_e==1, hi_e is ignored.
- Idle (active==0 or en[i]==0): cnt held 0, clk_out[i]=0, tick[i]=0.
- Start: the edge sampling en[i]==1 with active==0 sets active=1, cnt=0, clk_out[i]=1, tick[i]=1. The first high phase is visible the cycle after en rises.
- Run: cnt advances 0..div_e-1 and wraps to 0.
  - Outputs are registered from the new cnt: clk_out[i] = (cnt_new < hi_e); tick[i] = (cnt_new == 0).
  - Period = div_e cycles; high = hi_e cycles; low = div_e-hi_e cycles.
  - div_e==1: clk_out[i] constant 1 and tick[i] every cycle while active.
- Stop: the edge sampling en[i]==0 sets active=0, cnt=0, and both outputs to 0 in that same update.
- sync: the edge sampling sync==1 forces cnt=0, clk_out=1, tick=1 on every channel with en[i]==1, regardless of phase. Channels starting on that edge align with them. Idle channels are unaffected.
- Config handshake:
  - Accept when cfg_valid && cfg_ready: shadow[cfg_ch] <= {cfg_div, cfg_hi}, pending[cfg_ch] <= 1.
  - cfg_ch >= NCH: cfg_ready=1, write is dropped, no state change.
- Apply: shadow copies to div/hi and pending clears at the first edge, after the accept edge, where any of these holds:
  - the channel is running and cnt==div_e-1 (wrap),
  - sync hits the channel,
  - the channel is idle,
  - the channel starts or stops.
  - The new values govern the period beginning at that edge.
- Simultaneous events:
  - Accept and apply never share an edge for the same config; a write accepted on an edge applies no earlier than the next edge.
  - A second write to a pending channel stalls (cfg_ready=0) until the apply edge, then is accepted the following edge at the earliest.
  - sync + en fall on the same edge: the stop wins.
  - Reset overrides everything.
- All arithmetic is unsigned CW-bit; cnt never exceeds div_e-1. If a new div is smaller than the current cnt, it is still applied only at a wrap or sync, so overflow is impossible.

Test Plan:
- Default: release rst, en=4'b0001 → clk_out[0] toggles 1,0,1,0 (period 2) and tick[0] every 2 cycles starting 1 cycle after en; clk_out[3:1] stay 0.
- Program ch1 div=5 hi=2 while idle, then en[1]=1 → pattern 1,1,0,0,0 repeating; tick[1] on each first 1; cfg_ready low for exactly one cycle after accept.
- Reconfigure running ch0 (div 5→3, hi 1) at cnt=1 → current 5-cycle period completes unchanged, next period is 1,0,0; cfg_ready for ch0 is 0 until the apply edge; a second write stalls until then.
- Run ch0 div=4 and ch2 div=6 out of phase, pulse sync → both tick on the same cycle after sync; idle ch3 unaffected.
- Clamp cases: div=0 → clk_out constant 1, tick every cycle; div=4 hi=9 → hi_e=3 (1,1,1,0); hi=0 → hi_e=1.
- Assert rst=0 mid-period with a pending config → next edge all outputs 0, cfg_ready=1, and after release the defaults (div 2, hi 1) are in force.
